// File: rtl/pakin.sv
// pakin: packet-to-message reassembly stage.
// Collects NP = ceil((ASZ+DSZ)/PSZ) packets (LS chunk first) into one message,
// queues finished messages in an FSZ-deep FIFO and re-issues them on a
// four-phase message channel.
// Optional feature macro: NS_PAKIN_BYPASS_EN -- when defined, a message that
// completes while the FIFO and output channel are idle skips the FIFO.
`timescale 1ns/1ps

`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 4
`endif
`ifndef NS_MESSAGE_FIFO_SIZE
`define NS_MESSAGE_FIFO_SIZE 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 4
`endif

module pakin #(
   parameter int PSZ = `NS_PACKET_SIZE,
   parameter int FSZ = `NS_MESSAGE_FIFO_SIZE,
   parameter int ASZ = `NS_ADDRESS_SIZE,
   parameter int DSZ = `NS_DATA_SIZE
) (
   input  logic                 i_clk,
   input  logic                 reset,
   output logic                 ready,
   input  logic                 rcv0_req,
   input  logic [PSZ-1:0]       rcv0_pak,
   output logic                 rcv0_ack,
   output logic                 snd0_req,
   output logic [ASZ+DSZ-1:0]   snd0_msg,
   input  logic                 snd0_ack
);

   localparam int MSZ = ASZ + DSZ;
   localparam int NP  = ((MSZ + PSZ - 1) / PSZ < 1) ? 1 : (MSZ + PSZ - 1) / PSZ;
   localparam int CW  = (NP > 1) ? $clog2(NP) : 1;
   localparam int AW  = $clog2(FSZ);
   localparam int RW  = NP * PSZ;

   localparam logic [CW-1:0] LAST_SLOT = CW'(NP - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FSZ);

   logic            ready_q, rack_q, sreq_q;
   logic            rack_d, sreq_d;
   logic [MSZ-1:0]  smsg_q, smsg_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   asm_q, asm_d;
   logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [AW:0]     count_q, count_d;
   logic [MSZ-1:0]  mem [FSZ];

   logic full, empty, last_slot, accept, complete, pop, push, bypass;
   logic [MSZ-1:0] msg_full;

   // Accept/push/pop decisions and next-state values
   always_comb begin
      full      = (count_q == FULL_CNT);
      empty     = (count_q == '0);
      last_slot = (cnt_q == LAST_SLOT);
      // the last packet of a message needs FIFO room as of before this edge
      accept    = ready_q & rcv0_req & ~rack_q & (~last_slot | ~full);
      complete  = accept & last_slot;

      asm_d = asm_q;
      if (accept)
         asm_d[cnt_q*PSZ +: PSZ] = rcv0_pak;
      // padding bits above MSZ in the last packet are dropped here
      msg_full = asm_d[MSZ-1:0];

      pop = ~sreq_q & ~snd0_ack & ~empty;
`ifdef NS_PAKIN_BYPASS_EN
      bypass = complete & empty & ~sreq_q & ~snd0_ack;
`else
      bypass = 1'b0;
`endif
      push = complete & ~bypass;

      cnt_d = cnt_q;
      if (accept)
         cnt_d = last_slot ? '0 : cnt_q + CW'(1);

      rack_d = rack_q;
      if (accept)
         rack_d = 1'b1;
      else if (!rcv0_req)
         rack_d = 1'b0;

      sreq_d = sreq_q;
      smsg_d = smsg_q;
      if (sreq_q && snd0_ack)
         sreq_d = 1'b0;
      else if (pop) begin
         sreq_d = 1'b1;
         smsg_d = mem[head_q];
      end else if (bypass) begin
         sreq_d = 1'b1;
         smsg_d = msg_full;
      end

      head_d  = head_q + AW'(pop);
      tail_d  = tail_q + AW'(push);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   // Control and datapath registers, all cleared by reset
   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         ready_q <= 1'b0;
         rack_q  <= 1'b0;
         sreq_q  <= 1'b0;
         smsg_q  <= '0;
         cnt_q   <= '0;
         asm_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         ready_q <= 1'b1;
         rack_q  <= rack_d;
         sreq_q  <= sreq_d;
         smsg_q  <= smsg_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // FIFO storage; contents are only meaningful between the pointers
   always_ff @(posedge i_clk) begin
      if (push)
         mem[tail_q] <= msg_full;
   end

   assign ready    = ready_q;
   assign rcv0_ack = rack_q;
   assign snd0_req = sreq_q;
   assign snd0_msg = smsg_q;

endmodule
